keypad_entry_scanner: RTL and testbench
=======================================

# keypad_entry_scanner

Input-side counterpart to the four-digit seven-segment display path: scans a 4x4 matrix keypad, debounces key presses, assembles up to four decimal digits, and on Enter converts them to a 16-bit binary value for the RISC-V processor's I/O. The live BCD digits are exported so the existing display driver can echo entry in progress.

## Interface
- SCAN_DIV, 65536: clock cycles each column is driven; minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; minimum 1.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- col_out  output  4  column drive, active-low, exactly one bit low.
- key_code  output  4  code of the last accepted key.
- key_strobe  output  1  one-cycle pulse on each accepted press.
- bcd  output  16  digits entered so far, {d3,d2,d1,d0}, newest digit in d0.
- num  output  16  binary result of the last Enter, zero-extended, held until the next Enter.
- num_valid  output  1  one-cycle pulse when num updates.

## Operation
- Key map, row,col → code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Key meanings: A = Enter, B = Backspace, C = Clear; D, E, F are accepted and strobed but have no entry effect.
- Scanning:
  - row_in passes through a 2-flop synchronizer.
  - The column index advances 0→1→2→3→0 every SCAN_DIV cycles.
  - Rows are sampled on the last dwell cycle of each column.
  - After column 3 the scan result is one of: none, single key (code), or multiple. A multiple-key result is treated as none.
- Debounce:
  - A press is accepted when the same single key is seen for DEBOUNCE_SCANS consecutive scans while released.
  - Acceptance pulses key_strobe and latches key_code.
  - Return to released state requires DEBOUNCE_SCANS consecutive none scans.
  - A different key while pressed does not retrigger. No auto-repeat.
- Entry FSM, states IDLE, CONV, DONE:
  - IDLE, digit with count<4: bcd ← {bcd[11:0],digit}, count+1.
  - IDLE, digit with count=4: ignored; bcd is unchanged.
  - IDLE, Backspace: bcd ← {4'h0,bcd[15:4]}, count−1. No effect when count=0.
  - IDLE, Clear: bcd ← 0, count ← 0.
  - IDLE, Enter: go to CONV with acc ← 0, regardless of count.
  - CONV, 4 cycles, d3 first: acc ← acc*10 + digit, where *10 = (acc<<3)+(acc<<1), 14-bit accumulator. Then go to DONE.
  - DONE, 1 cycle: num ← {2'b0,acc}, num_valid=1, bcd ← 0, count ← 0. Then go to IDLE.
  - Key events arriving in CONV or DONE are dropped. They still strobe.
- Range: 0..9999. Converted digit values are always 0–9 because entry is the only source of bcd.

## Timing
- Reset values:
  - col_out=4'b1110
  - key_code=0, key_strobe=0
  - bcd=0, num=0, num_valid=0
  - count=0, state IDLE, debounce state released, scan counters 0
- Press to strobe: at most (DEBOUNCE_SCANS+1)·4·SCAN_DIV + 3 cycles after the rows go stable.
- Entry-register updates occur in the cycle after key_strobe.
- Enter strobe at cycle T: CONV occupies T+1..T+4; num and num_valid in T+5; bcd reads 0 from T+6.
- Reset asserted mid-scan or mid-CONV: all state returns to reset values immediately. No num_valid is produced, and num stays 0.
- col_out is registered and changes only at dwell boundaries.

## Structure
- Package keypad_pkg holds:
  - key code constants KEY_ENTER=4'hA, KEY_BSP=4'hB, KEY_CLR=4'hC
  - entry FSM state enum
  - the key map function from (row,col) to code
- Sub-module bcd4_to_bin holds the sequential CONV datapath: start, 16-bit bcd in, 14-bit result, done.
- The scanner, synchronizer and debouncer stay in the top module.

## Test plan
Benches use SCAN_DIV=4, DEBOUNCE_SCANS=2.
- Reset: col_out=1110, all outputs 0. Idle rows=1111 for 50 scans → no key_strobe.
- Press 1,2,3,4 then Enter:
  - bcd steps 0x0001, 0x0012, 0x0123, 0x1234.
  - num=16'h04D2 with a single num_valid pulse exactly 5 cycles after the Enter strobe.
  - bcd=0 afterwards.
- Entry edits:
  - After 1234, press 5 → bcd stays 0x1234.
  - Backspace → 0x0123.
  - Clear → 0x0000.
  - Enter with no digits → num=0 and num_valid pulses.
- Debounce:
  - Key 7 held for only 1 scan, repeated → no strobe.
  - Key 7 held for 20 scans → exactly one strobe, key_code=7.
  - Keys 2 and 5 pressed together → no strobe.
- Range and reset:
  - 9,9,9,9, Enter → num=16'h270F.
  - Repeat the entry and assert rst_n low in cycle T+2 of CONV → num=0, num_valid never asserts.

Source files
------------

// File: rtl/keypad_entry_scanner_pkg.sv
// Shared definitions for the keypad entry path: key codes, entry FSM states
// and the physical row/column to key-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BSP   = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } entry_state_t;

    // Row 3 carries the '*' and '#' keys, reported as E and F.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_scanner_bcd4_to_bin.sv
// Four-digit BCD to binary converter, one digit per cycle, most significant
// digit first. The result register holds until the next conversion finishes.
module bcd4_to_bin
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bcd,
    output logic [13:0] result,
    output logic        done
);

    logic [13:0] acc;
    logic [1:0]  idx;
    logic        busy;
    logic [3:0]  digit;
    logic [13:0] acc_next;

    // Select the digit for this step and form acc*10 + digit with shifts.
    always_comb begin
        digit = 4'h0;
        case (idx)
            2'd3: digit = bcd[15:12];
            2'd2: digit = bcd[11:8];
            2'd1: digit = bcd[7:4];
            2'd0: digit = bcd[3:0];
        endcase
        acc_next = (acc << 3) + (acc << 1) + {10'd0, digit};
    end

    // Step through d3..d0; publish the result and pulse done on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                acc <= acc_next;
                if (idx == 2'd0) begin
                    busy   <= 1'b0;
                    result <= acc_next;
                    done   <= 1'b1;
                end else begin
                    idx <= idx - 2'd1;
                end
            end else if (start) begin
                acc  <= '0;
                idx  <= 2'd3;
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad scanner with debounce and four-digit decimal entry.
// Enter converts the entered digits to binary through bcd4_to_bin.
//
// state   | meaning
// IDLE    | accepting digits and edit keys
// CONV    | converter stepping through d3..d0 (4 cycles), keys dropped
// DONE    | result published, entry cleared, keys dropped
module keypad_entry_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 65536,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic [15:0] bcd,
    output logic [15:0] num,
    output logic        num_valid
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             scan_hit, scan_multi;
    logic [3:0]       scan_code;

    logic             dwell_end, scan_done;
    logic [3:0]       rows_low;
    logic             col_none, col_single;
    logic [1:0]       row_idx;
    logic [3:0]       col_code;
    logic             hit_nx, multi_nx;
    logic [3:0]       code_nx;
    logic             res_single;

    logic             pressed;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_plus;
    logic [3:0]       cand_code;

    entry_state_t     state;
    logic [2:0]       count;
    logic [1:0]       conv_left;
    logic             conv_start;
    logic [13:0]      conv_result;
    logic             conv_done;

    // Decode this column's rows and fold them into the running scan result.
    always_comb begin
        dwell_end  = (div_cnt == DIV_LAST);
        scan_done  = dwell_end && (col_idx == 2'd3);
        rows_low   = ~row_sync;
        col_none   = (rows_low == 4'h0);
        col_single = !col_none && ((rows_low & (rows_low - 4'd1)) == 4'h0);
        row_idx    = 2'd3;
        casez (rows_low)
            4'b???1: row_idx = 2'd0;
            4'b??10: row_idx = 2'd1;
            4'b?100: row_idx = 2'd2;
            default: row_idx = 2'd3;
        endcase
        col_code   = key_map(row_idx, col_idx);
        hit_nx     = scan_hit || !col_none;
        multi_nx   = scan_multi || (!col_none && (!col_single || scan_hit));
        code_nx    = (!scan_hit && col_single) ? col_code : scan_code;
        res_single = hit_nx && !multi_nx;
        db_plus    = db_cnt + DB_W'(1);
    end

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Column dwell timer, column drive, and per-scan accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            col_idx    <= 2'd0;
            col_out    <= 4'b1110;
            scan_hit   <= 1'b0;
            scan_multi <= 1'b0;
            scan_code  <= 4'h0;
        end else if (dwell_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            col_out <= {col_out[2:0], col_out[3]};
            if (scan_done) begin
                scan_hit   <= 1'b0;
                scan_multi <= 1'b0;
                scan_code  <= 4'h0;
            end else begin
                scan_hit   <= hit_nx;
                scan_multi <= multi_nx;
                scan_code  <= code_nx;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Debounce: accept a stable single key while released, then wait for
    // a stable run of empty scans before re-arming. db_cnt==0 means no candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed    <= 1'b0;
            db_cnt     <= '0;
            cand_code  <= 4'h0;
            key_code   <= 4'h0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (scan_done) begin
                if (!pressed) begin
                    if (res_single) begin
                        cand_code <= code_nx;
                        if (db_cnt != '0 && code_nx == cand_code) begin
                            if (db_plus == DB_TARGET) begin
                                pressed    <= 1'b1;
                                db_cnt     <= '0;
                                key_code   <= code_nx;
                                key_strobe <= 1'b1;
                            end else begin
                                db_cnt <= db_plus;
                            end
                        end else if (DB_TARGET == DB_W'(1)) begin
                            pressed    <= 1'b1;
                            db_cnt     <= '0;
                            key_code   <= code_nx;
                            key_strobe <= 1'b1;
                        end else begin
                            db_cnt <= DB_W'(1);
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end else begin
                    if (!res_single) begin
                        if (db_plus == DB_TARGET) begin
                            pressed <= 1'b0;
                            db_cnt  <= '0;
                        end else begin
                            db_cnt <= db_plus;
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end
            end
        end
    end

    assign conv_start = key_strobe && (state == ST_IDLE) && (key_code == KEY_ENTER);

    // Entry FSM: digit shifting and editing in IDLE, conversion sequencing after Enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bcd       <= 16'h0000;
            count     <= 3'd0;
            conv_left <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_strobe) begin
                        if (key_code <= 4'd9) begin
                            if (count != 3'd4) begin
                                bcd   <= {bcd[11:0], key_code};
                                count <= count + 3'd1;
                            end
                        end else if (key_code == KEY_BSP) begin
                            if (count != 3'd0) begin
                                bcd   <= {4'h0, bcd[15:4]};
                                count <= count - 3'd1;
                            end
                        end else if (key_code == KEY_CLR) begin
                            bcd   <= 16'h0000;
                            count <= 3'd0;
                        end else if (key_code == KEY_ENTER) begin
                            state     <= ST_CONV;
                            conv_left <= 2'd3;
                        end
                    end
                end
                ST_CONV: begin
                    if (conv_left == 2'd0) begin
                        state <= ST_DONE;
                    end else begin
                        conv_left <= conv_left - 2'd1;
                    end
                end
                ST_DONE: begin
                    bcd   <= 16'h0000;
                    count <= 3'd0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bcd4_to_bin u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start),
        .bcd    (bcd),
        .result (conv_result),
        .done   (conv_done)
    );

    assign num       = {2'b00, conv_result};
    assign num_valid = conv_done;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner with a behavioural 4x4 keypad.
module tb_keypad_entry_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic [15:0] bcd;
    logic [15:0] num;
    logic        num_valid;

    keypad_entry_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .col_out    (col_out),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .bcd        (bcd),
        .num        (num),
        .num_valid  (num_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: bit r*4+c set means the key at row r, column c is held.
    logic [15:0] keys;
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    int cyc = 0;
    int strobe_cnt = 0, strobe_cyc = 0;
    int nv_cnt = 0, nv_cyc = 0;
    logic [15:0] nv_num = 16'h0;
    int total = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
        end
        if (num_valid) begin
            nv_cnt = nv_cnt + 1;
            nv_cyc = cyc;
            nv_num = num;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int base, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (strobe_cnt > base) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  r;
        logic [1:0]  c;
        logic [3:0]  code;
        logic [15:0] exp_bcd;
        bit          is_enter;
        logic [15:0] exp_num;
    } vec_t;

    vec_t vecs[18];

    // Press one key, expect a single strobe with the given code, release,
    // then check the entry register; for Enter also check num timing/value.
    task automatic press(input vec_t v, input string tag);
        int  base, nvb, t;
        bit  seen;
        base = strobe_cnt;
        nvb  = nv_cnt;
        keys = 16'h0;
        keys[{v.r, v.c}] = 1'b1;
        wait_strobe(base, seen);
        check({tag, "_strobe_seen"}, 32'(seen), 32'd1);
        check({tag, "_key_code"}, 32'(key_code), 32'(v.code));
        t = strobe_cyc;
        tick(10);
        if (v.is_enter) begin
            check({tag, "_nv_pulses"}, 32'(nv_cnt - nvb), 32'd1);
            check({tag, "_nv_latency"}, 32'(nv_cyc - t), 32'd5);
            check({tag, "_num"}, 32'(nv_num), 32'(v.exp_num));
        end
        keys = 16'h0;
        tick(80);
        check({tag, "_one_strobe"}, 32'(strobe_cnt - base), 32'd1);
        check({tag, "_bcd"}, 32'(bcd), 32'(v.exp_bcd));
    endtask

    initial begin
        int  base, nvb, t;
        bit  seen;

        vecs[0]  = '{2'd0, 2'd0, 4'h1, 16'h0001, 1'b0, 16'h0};
        vecs[1]  = '{2'd0, 2'd1, 4'h2, 16'h0012, 1'b0, 16'h0};
        vecs[2]  = '{2'd0, 2'd2, 4'h3, 16'h0123, 1'b0, 16'h0};
        vecs[3]  = '{2'd1, 2'd0, 4'h4, 16'h1234, 1'b0, 16'h0};
        vecs[4]  = '{2'd0, 2'd3, 4'hA, 16'h0000, 1'b1, 16'h04D2};
        vecs[5]  = '{2'd0, 2'd0, 4'h1, 16'h0001, 1'b0, 16'h0};
        vecs[6]  = '{2'd0, 2'd1, 4'h2, 16'h0012, 1'b0, 16'h0};
        vecs[7]  = '{2'd0, 2'd2, 4'h3, 16'h0123, 1'b0, 16'h0};
        vecs[8]  = '{2'd1, 2'd0, 4'h4, 16'h1234, 1'b0, 16'h0};
        vecs[9]  = '{2'd1, 2'd1, 4'h5, 16'h1234, 1'b0, 16'h0};
        vecs[10] = '{2'd1, 2'd3, 4'hB, 16'h0123, 1'b0, 16'h0};
        vecs[11] = '{2'd2, 2'd3, 4'hC, 16'h0000, 1'b0, 16'h0};
        vecs[12] = '{2'd0, 2'd3, 4'hA, 16'h0000, 1'b1, 16'h0000};
        vecs[13] = '{2'd2, 2'd2, 4'h9, 16'h0009, 1'b0, 16'h0};
        vecs[14] = '{2'd2, 2'd2, 4'h9, 16'h0099, 1'b0, 16'h0};
        vecs[15] = '{2'd2, 2'd2, 4'h9, 16'h0999, 1'b0, 16'h0};
        vecs[16] = '{2'd2, 2'd2, 4'h9, 16'h9999, 1'b0, 16'h0};
        vecs[17] = '{2'd0, 2'd3, 4'hA, 16'h0000, 1'b1, 16'h270F};

        keys  = 16'h0;
        rst_n = 1'b0;
        tick(3);
        check("rst_col_out", 32'(col_out), 32'hE);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_strobe", 32'(key_strobe), 32'h0);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_num", 32'(num), 32'h0);
        check("rst_num_valid", 32'(num_valid), 32'h0);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_col_out", 32'(col_out), 32'hE);

        tick(50 * 16);
        check("idle_no_strobe", 32'(strobe_cnt), 32'd0);

        for (int i = 0; i < 18; i++) press(vecs[i], $sformatf("vec%0d", i));

        // Key 7 held for one scan at a time: must never be accepted.
        base = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0;
            keys[8] = 1'b1;
            tick(16);
            keys = 16'h0;
            tick(48);
        end
        check("short7_no_strobe", 32'(strobe_cnt - base), 32'd0);

        // Key 7 held for 20 scans: one strobe, no auto-repeat.
        base = strobe_cnt;
        keys = 16'h0;
        keys[8] = 1'b1;
        tick(20 * 16);
        keys = 16'h0;
        tick(80);
        check("long7_strobes", 32'(strobe_cnt - base), 32'd1);
        check("long7_key_code", 32'(key_code), 32'h7);
        check("long7_bcd", 32'(bcd), 32'h0007);

        // Keys 2 and 5 together (same column) are a multiple-key scan.
        base = strobe_cnt;
        keys = 16'h0;
        keys[1] = 1'b1;
        keys[5] = 1'b1;
        tick(20 * 16);
        keys = 16'h0;
        tick(80);
        check("multi_no_strobe", 32'(strobe_cnt - base), 32'd0);

        // 9999 again, then reset in the second cycle of conversion.
        press('{2'd2, 2'd3, 4'hC, 16'h0000, 1'b0, 16'h0}, "rclr");
        for (int i = 13; i < 17; i++) press(vecs[i], $sformatf("r9_%0d", i));
        base = strobe_cnt;
        nvb  = nv_cnt;
        keys = 16'h0;
        keys[3] = 1'b1;
        wait_strobe(base, seen);
        check("renter_strobe_seen", 32'(seen), 32'd1);
        t = strobe_cyc;
        @(posedge clk);
        #1;
        check("renter_in_T2", 32'(cyc - t), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_num", 32'(num), 32'h0);
        check("mid_rst_bcd", 32'(bcd), 32'h0);
        check("mid_rst_col_out", 32'(col_out), 32'hE);
        check("mid_rst_num_valid", 32'(num_valid), 32'h0);
        tick(5);
        keys = 16'h0;
        rst_n = 1'b1;
        tick(40);
        check("mid_rst_no_nv", 32'(nv_cnt - nvb), 32'd0);
        check("mid_rst_num_hold", 32'(num), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
